// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/subtract unit with the carry chain cut into
// SEG_W-bit segments, one pipeline stage per segment (STAGES = WIDTH/SEG_W).
// Operands are registered on acceptance; each following stage adds one
// segment, so a result appears STAGES cycles after the accepting edge.
// A single global stall (advance) freezes every stage while the output waits.
// Optional build macro: ADDER_SAT_EN -- saturate out_sum on signed overflow.
module pipelined_adder #(
  parameter int WIDTH = 16,
  parameter int SEG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int STAGES = WIDTH / SEG_W;

  // Slot k holds the operation waiting to be processed by stage k. Slot 0 is
  // the acceptance register; the last stage writes the out_* registers.
  logic [STAGES-1:0] v_q;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];  // effective B (already inverted for subtract)
  logic [WIDTH-1:0]  s_q [STAGES];  // lower sum segments computed so far
  logic [STAGES-1:0] c_q;           // carry into segment k

  logic [WIDTH-1:0]  s_nxt [STAGES];
  logic [STAGES-1:0] c_nxt;

  logic             advance;
  logic [WIDTH-1:0] fin_sum;
  logic [WIDTH-1:0] res_sum;
  logic             fin_cout;
  logic             fin_ovf;
  logic             a_msb;
  logic             b_msb;

  // Global stall: every stage moves only when the output slot can drain.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Per-stage segment add: stage k fills in sum segment k and its carry.
  // NOTE: every variable written here gets a value before any conditional or
  // partial update, so no latch can be inferred.
  always_comb begin
    logic [SEG_W:0] seg;
    seg   = '0;
    c_nxt = '0;
    for (int k = 0; k < STAGES; k++) begin
      seg = {1'b0, a_q[k][k*SEG_W +: SEG_W]}
          + {1'b0, b_q[k][k*SEG_W +: SEG_W]}
          + (SEG_W+1)'(c_q[k]);
      s_nxt[k] = s_q[k];
      s_nxt[k][k*SEG_W +: SEG_W] = seg[SEG_W-1:0];
      c_nxt[k] = seg[SEG_W];
    end
  end

  // Final-stage result: carry-out, signed overflow and optional saturation.
  always_comb begin
    fin_sum  = s_nxt[STAGES-1];
    fin_cout = c_nxt[STAGES-1];
    a_msb    = a_q[STAGES-1][WIDTH-1];
    b_msb    = b_q[STAGES-1][WIDTH-1];
    fin_ovf  = (a_msb == b_msb) && (fin_sum[WIDTH-1] != a_msb);
`ifdef ADDER_SAT_EN
    if (fin_ovf) begin
      res_sum = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      res_sum = fin_sum;
    end
`else
    res_sum = fin_sum;
`endif
  end

  // Operand/partial-sum datapath: shifts one slot per advance, no reset.
  // NOTE: these payload registers are deliberately not reset; their content is
  // only ever observed under a valid bit, and that is what reset clears.
  always_ff @(posedge clk) begin
    if (advance) begin
      if (in_valid) begin
        a_q[0] <= in_a;
        b_q[0] <= in_sub ? ~in_b : in_b;
        c_q[0] <= in_sub | in_cin;
        s_q[0] <= '0;
      end
      for (int k = 1; k < STAGES; k++) begin
        a_q[k] <= a_q[k-1];
        b_q[k] <= b_q[k-1];
        s_q[k] <= s_nxt[k-1];
        c_q[k] <= c_nxt[k-1];
      end
    end
  end

  // Valid bits and output registers: cleared by reset, frozen on stall.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_q       <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
    end else if (advance) begin
      v_q[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) begin
        v_q[k] <= v_q[k-1];
      end
      out_valid <= v_q[STAGES-1];
      if (v_q[STAGES-1]) begin
        out_sum  <= res_sum;
        out_cout <= fin_cout;
        out_ovf  <= fin_ovf;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed bench for pipelined_adder (WIDTH=16, SEG_W=4).
// Expected results are queued at acceptance and popped when the DUT delivers.
module tb_pipelined_adder;

  localparam int WIDTH  = 16;
  localparam int SEG_W  = 4;
  localparam int STAGES = WIDTH / SEG_W;
`ifdef ADDER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  exp_t sb[$];
  int   pop_cycs[$];
  exp_t mon_e;

  pipelined_adder #(.WIDTH(WIDTH), .SEG_W(SEG_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_cin   (in_cin),
    .in_sub   (in_sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout),
    .out_ovf  (out_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [WIDTH-1:0] sum, input logic cout, input logic ovf);
    exp_t e;
    e.sum  = sum;
    e.cout = cout;
    e.ovf  = ovf;
    return e;
  endfunction

  // Reference: one full-width add of the effective operands.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input logic sub);
    logic [WIDTH-1:0] be;
    logic [WIDTH:0]   full;
    exp_t             e;
    be     = sub ? ~b : b;
    full   = {1'b0, a} + {1'b0, be} + {{WIDTH{1'b0}}, (sub | cin)};
    e.sum  = full[WIDTH-1:0];
    e.cout = full[WIDTH];
    e.ovf  = (a[WIDTH-1] == be[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
    if (SAT && e.ovf) e.sum = a[WIDTH-1] ? 16'h8000 : 16'h7FFF;
    return e;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one operation and hold it until accepted (bounded).
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic cin, input logic sub, input bit push, input exp_t e);
    bit done;
    done     = 1'b0;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_sub   = sub;
    in_valid = 1'b1;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1'b1;
        if (push) sb.push_back(e);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) check("accept_timeout", 32'(done), 32'd1);
  endtask

  task automatic sendm(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic cin, input logic sub);
    send(a, b, cin, sub, 1'b1, model(a, b, cin, sub));
  endtask

  task automatic latency_check(input string tag);
    for (int i = 1; i <= STAGES; i++) begin
      @(posedge clk);
      #1;
      check(tag, 32'(out_valid), 32'(i == STAGES));
    end
  endtask

  // Output monitor: pop and compare every delivered result.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      pop_cycs.push_back(cyc);
      if (sb.size() == 0) begin
        check("spurious_out", 32'(sb.size()), 32'd1);
      end else begin
        mon_e = sb.pop_front();
        check("out_sum", 32'(out_sum), 32'(mon_e.sum));
        check("out_cout", 32'(out_cout), 32'(mon_e.cout));
        check("out_ovf", 32'(out_ovf), 32'(mon_e.ovf));
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    in_sub    = 1'b0;
    out_ready = 1'b1;

    // Reset state.
    idle(2);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_cout", 32'(out_cout), 32'd0);
    check("rst_out_ovf", 32'(out_ovf), 32'd0);
    reset = 1'b1;
    idle(1);
    check("idle_in_ready", 32'(in_ready), 32'd1);

    // Carry ripple through every segment, with exact latency.
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, mk(16'h0000, 1'b1, 1'b0));
    latency_check("ripple_latency");
    idle(3);

    // Subtract and signed-overflow corners, back to back.
    send(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1, mk(16'hFFFE, 1'b0, 1'b0));
    send(16'h0007, 16'h0005, 1'b0, 1'b1, 1'b1, mk(16'h0002, 1'b1, 1'b0));
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, mk(SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1));
    send(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, mk(SAT ? 16'h8000 : 16'h7FFF, 1'b1, 1'b1));
    idle(STAGES + 3);
    check("corner_drained", 32'(sb.size()), 32'd0);

    // Throughput: 8 ops on 8 consecutive cycles, results on 8 consecutive cycles.
    pop_cycs.delete();
    acc0 = 0;
    for (int i = 0; i < 8; i++) begin
      sendm(16'(i), 16'(i), 1'b1, 1'b0);
      if (i == 0) acc0 = cyc;
    end
    idle(12);
    check("tput_count", 32'(pop_cycs.size()), 32'd8);
    if (pop_cycs.size() == 8) begin
      check("tput_first_cycle", 32'(pop_cycs[0]), 32'(acc0 + STAGES));
      check("tput_last_cycle", 32'(pop_cycs[7]), 32'(acc0 + STAGES + 7));
    end

    // Backpressure: fill the pipe, stall 3 cycles, then drain while accepting.
    out_ready = 1'b0;
    for (int i = 0; i < STAGES + 1; i++) begin
      sendm(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    end
    check("bp_full_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_held_sum", 32'(out_sum), 32'(sb[0].sum));
      check("bp_held_cout", 32'(out_cout), 32'(sb[0].cout));
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sendm(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    end
    idle(12);
    check("bp_drained", 32'(sb.size()), 32'd0);

    // Reset mid-flight: in-flight ops vanish, next op has full latency.
    out_ready = 1'b0;
    send(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, mk(16'h0, 1'b0, 1'b0));
    send(16'h3333, 16'h4444, 1'b0, 1'b0, 1'b0, mk(16'h0, 1'b0, 1'b0));
    idle(STAGES - 1);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    reset     = 1'b1;
    out_ready = 1'b1;
    pop_cycs.delete();
    idle(8);
    check("post_rst_no_stale", 32'(pop_cycs.size()), 32'd0);
    sendm(16'h1234, 16'h0F0F, 1'b0, 1'b0);
    latency_check("post_rst_latency");
    idle(3);

    check("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
